// File: rtl/fifo_pkg.sv
// Shared FIFO types used by the UART and JTAG data-path FIFOs.
package fifo_pkg;

  // Read-port flavour: show-ahead (combinational) or one-cycle registered.
  typedef enum logic {
    RD_COMB = 1'b0,
    RD_REG  = 1'b1
  } fifo_rd_mode_e;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Wrapping pointer for an arbitrary-depth FIFO: counts 0..DEPTH-1 and wraps to 0.
module fifo_wrap_ptr #(
  parameter int DEPTH = 16,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  // Advance on inc with an explicit wrap at the last slot, so non-power-of-two depths work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/flow_ctrl_fifo.sv
// Single-clock FIFO with level/free counters, threshold flags, flush and sticky error flags.
module flow_ctrl_fifo
  import fifo_pkg::*;
#(
  parameter int            WIDTH         = 8,
  parameter int            DEPTH         = 16,
  parameter fifo_rd_mode_e RD_MODE       = RD_COMB,
  parameter int            AFULL_THRESH  = DEPTH - 2,
  parameter int            AEMPTY_THRESH = 1,
  localparam int           CW            = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             almost_empty,
  output logic [CW-1:0]    level,
  output logic [CW-1:0]    free,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2) begin : g_chk_depth
    $error("flow_ctrl_fifo: DEPTH must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_chk_afull
    $error("flow_ctrl_fifo: AFULL_THRESH must be within 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= DEPTH) begin : g_chk_aempty
    $error("flow_ctrl_fifo: AEMPTY_THRESH must be within 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;
  logic             wr_err;
  logic             rd_err;

  // A read always frees a slot, so a write into a full FIFO is legal when a read is taken too.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);
  assign wr_err = wr_en & ~wr_acc & ~flush;
  assign rd_err = rd_en & ~rd_acc & ~flush;

  assign empty        = (level == '0);
  assign full         = (level == CW'(DEPTH));
  assign almost_full  = (level >= CW'(AFULL_THRESH));
  assign almost_empty = (level <= CW'(AEMPTY_THRESH));
  assign free         = CW'(DEPTH) - level;

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (wr_acc),
    .ptr (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (rd_acc),
    .ptr (rd_ptr)
  );

  // Storage array, intentionally unreset; flush drops the in-flight write.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Occupancy counter; simultaneous accepted read and write cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else if (flush) begin
      level <= '0;
    end else if (wr_acc && !rd_acc) begin
      level <= level + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      level <= level - 1'b1;
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_err | (overflow & ~err_clr);
      underflow <= rd_err | (underflow & ~err_clr);
    end
  end

  if (RD_MODE == RD_REG) begin : g_rd_reg
    logic [WIDTH-1:0] rd_data_p1;
    logic             vld_p1;

    // Stage p1: capture the head entry on an accepted read; data holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_p1 <= '0;
        vld_p1     <= 1'b0;
      end else begin
        vld_p1 <= rd_acc & ~flush;
        if (rd_acc && !flush) begin
          rd_data_p1 <= mem[rd_ptr];
        end
      end
    end

    assign rd_data  = rd_data_p1;
    assign rd_valid = vld_p1;
  end else begin : g_rd_comb
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = 1'b0;
  end

endmodule

// File: tb/tb_flow_ctrl_fifo.sv
// Randomized and directed checks of flow_ctrl_fifo against a queue-based reference model.
module tb_flow_ctrl_fifo;
  import fifo_pkg::*;

  localparam int DA = 16;
  localparam int DB = 5;
  localparam int AF_A = 14;
  localparam int AE_A = 1;
  localparam int AF_B = 4;
  localparam int AE_B = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       err_clr;

  logic       a_full, a_afull, a_empty, a_aempty, a_rvalid, a_ovf, a_udf;
  logic [7:0] a_rdata;
  logic [4:0] a_level, a_free;
  logic       b_full, b_afull, b_empty, b_aempty, b_rvalid, b_ovf, b_udf;
  logic [7:0] b_rdata;
  logic [2:0] b_level, b_free;

  always #5 clk = ~clk;

  flow_ctrl_fifo #(.WIDTH(8), .DEPTH(DA), .RD_MODE(RD_COMB)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(a_full), .almost_full(a_afull), .rd_en(rd_en), .rd_data(a_rdata),
    .rd_valid(a_rvalid), .empty(a_empty), .almost_empty(a_aempty),
    .level(a_level), .free(a_free), .overflow(a_ovf), .underflow(a_udf),
    .err_clr(err_clr)
  );

  flow_ctrl_fifo #(.WIDTH(8), .DEPTH(DB), .RD_MODE(RD_REG),
                   .AFULL_THRESH(AF_B), .AEMPTY_THRESH(AE_B)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(b_full), .almost_full(b_afull), .rd_en(rd_en), .rd_data(b_rdata),
    .rd_valid(b_rvalid), .empty(b_empty), .almost_empty(b_aempty),
    .level(b_level), .free(b_free), .overflow(b_ovf), .underflow(b_udf),
    .err_clr(err_clr)
  );

  // Reference model state
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         ova, uda, ovb, udb;
  bit         vb;
  logic [7:0] rdb;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    ova = 0; uda = 0; ovb = 0; udb = 0;
    vb = 0;
    rdb = 8'h00;
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic model_step();
    int  na, nb;
    bit  ra, wa, rb, wb;
    logic [7:0] tmp;
    na = qa.size();
    nb = qb.size();
    ra = rd_en && (na > 0);
    wa = wr_en && ((na < DA) || ra);
    rb = rd_en && (nb > 0);
    wb = wr_en && ((nb < DB) || rb);
    if (flush) begin
      qa.delete();
      qb.delete();
      vb = 0;
    end else begin
      if (ra) tmp = qa.pop_front();
      if (wa) qa.push_back(wr_data);
      vb = rb;
      if (rb) rdb = qb.pop_front();
      if (wb) qb.push_back(wr_data);
    end
    ova = (!flush && wr_en && !wa) || (ova && !err_clr);
    uda = (!flush && rd_en && !ra) || (uda && !err_clr);
    ovb = (!flush && wr_en && !wb) || (ovb && !err_clr);
    udb = (!flush && rd_en && !rb) || (udb && !err_clr);
  endtask

  task automatic check_all();
    int na, nb;
    na = qa.size();
    nb = qb.size();
    chk("a_level", a_level, na);
    chk("a_free", a_free, DA - na);
    chk("a_empty", a_empty, na == 0);
    chk("a_full", a_full, na == DA);
    chk("a_almost_full", a_afull, na >= AF_A);
    chk("a_almost_empty", a_aempty, na <= AE_A);
    chk("a_overflow", a_ovf, ova);
    chk("a_underflow", a_udf, uda);
    chk("a_rd_valid", a_rvalid, 1'b0);
    if (na > 0) chk("a_rd_data", a_rdata, qa[0]);
    chk("b_level", b_level, nb);
    chk("b_free", b_free, DB - nb);
    chk("b_empty", b_empty, nb == 0);
    chk("b_full", b_full, nb == DB);
    chk("b_almost_full", b_afull, nb >= AF_B);
    chk("b_almost_empty", b_aempty, nb <= AE_B);
    chk("b_overflow", b_ovf, ovb);
    chk("b_underflow", b_udf, udb);
    chk("b_rd_valid", b_rvalid, vb);
    chk("b_rd_data", b_rdata, rdb);
  endtask

  // One clock: drive at the falling edge, update the model, check at the next falling edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic c);
    wr_en = w; wr_data = d; rd_en = r; flush = f; err_clr = c;
    model_step();
    @(posedge clk);
    @(negedge clk);
    wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
    check_all();
  endtask

  // Asynchronous reset: outputs must return to reset values before any clock edge.
  task automatic do_reset();
    wr_en = 0; rd_en = 0; flush = 0; err_clr = 0; wr_data = 8'h00;
    rst = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    check_all();
  endtask

  initial begin
    int pw, pr;
    rst = 0; wr_en = 0; rd_en = 0; flush = 0; err_clr = 0; wr_data = 8'h00;
    #3;
    do_reset();

    // Fill and drain in order
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);

    // Wrap-around on the five-entry instance
    for (int i = 0; i < 3; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h18 + i), 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);

    // Full with concurrent read+write, then overflow and clear
    for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 1, 0, 0);
    step(1, 8'h77, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);

    // Read on empty with simultaneous write
    step(1, 8'hA5, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);

    // Flush with a write pending; sticky flags survive
    for (int i = 0; i < 7; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
    step(1, 8'hEE, 0, 1, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);

    // Randomized traffic with shifting bias, occasional flush/err_clr, one mid-run reset
    pw = 50; pr = 50;
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0) begin
        case ($urandom_range(2))
          0: begin pw = 85; pr = 20; end
          1: begin pw = 20; pr = 85; end
          default: begin pw = 60; pr = 60; end
        endcase
      end
      if (n == 300) begin
        do_reset();
      end else begin
        step(($urandom_range(99) < pw) ? 1'b1 : 1'b0,
             8'($urandom_range(255)),
             ($urandom_range(99) < pr) ? 1'b1 : 1'b0,
             ($urandom_range(99) < 2) ? 1'b1 : 1'b0,
             ($urandom_range(99) < 5) ? 1'b1 : 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
